// File: rtl/spike_seq_ctrl.sv
// Frame sequencer for a bank of spikifier channels: integrate/compare phasing and saturating spike counting.
// Optional SPIKE_SEQ_CTRL_SAT_FLAG_EN adds a per-channel saturation flag output.
module spike_seq_ctrl #(
  parameter int NCH   = 4,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [7:0]           int_len,
  input  logic [3:0]           settle_len,
  input  logic [7:0]           frame_len,
  output logic                 phase,
  input  logic [NCH-1:0]       q_in,
  output logic [NCH*CNT_W-1:0] cnt_data,
  output logic                 cnt_valid,
  input  logic                 cnt_ready,
`ifdef SPIKE_SEQ_CTRL_SAT_FLAG_EN
  output logic [NCH-1:0]       sat_flag,
`endif
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, INTEG, COMP, OUT} state_t;

  state_t           r_state, w_next;
  logic [7:0]       r_int_len, r_frame_len, r_cycle, r_period;
  logic [3:0]       r_settle_len;
  logic [CNT_W-1:0] r_cnt [NCH];

  logic [7:0] w_int_eff, w_frame_eff;
  logic       w_int_last, w_comp_last, w_frame_last;

  // Zero lengths behave as one so every period and frame makes progress.
  assign w_int_eff    = (r_int_len == 8'd0)   ? 8'd1 : r_int_len;
  assign w_frame_eff  = (r_frame_len == 8'd0) ? 8'd1 : r_frame_len;
  assign w_int_last   = (r_cycle == w_int_eff - 8'd1);
  assign w_comp_last  = (r_cycle == {4'b0000, r_settle_len});
  assign w_frame_last = (r_period == w_frame_eff - 8'd1);

  always_comb begin
    w_next    = r_state;
    phase     = 1'b1;
    cnt_valid = 1'b0;
    busy      = 1'b1;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) w_next = INTEG;
      end
      INTEG: begin
        phase = 1'b0;
        if (w_int_last) w_next = COMP;
      end
      COMP: begin
        if (w_comp_last) w_next = w_frame_last ? OUT : INTEG;
      end
      OUT: begin
        cnt_valid = 1'b1;
        if (cnt_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_int_len    <= '0;
      r_settle_len <= '0;
      r_frame_len  <= '0;
      r_cycle      <= '0;
      r_period     <= '0;
      for (int unsigned i = 0; i < NCH; i++) r_cnt[i] <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_int_len    <= int_len;
            r_settle_len <= settle_len;
            r_frame_len  <= frame_len;
            r_cycle      <= '0;
            r_period     <= '0;
            for (int unsigned i = 0; i < NCH; i++) r_cnt[i] <= '0;
          end
        end
        INTEG: r_cycle <= w_int_last ? 8'd0 : r_cycle + 8'd1;
        COMP: begin
          if (w_comp_last) begin
            r_cycle  <= '0;
            r_period <= r_period + 8'd1;
            // Only the final settle cycle samples q, so each period counts once.
            for (int unsigned i = 0; i < NCH; i++)
              if (q_in[i] && (r_cnt[i] != '1)) r_cnt[i] <= r_cnt[i] + 1'b1;
          end else begin
            r_cycle <= r_cycle + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    cnt_data = '0;
    for (int unsigned i = 0; i < NCH; i++) cnt_data[i*CNT_W +: CNT_W] = r_cnt[i];
  end

`ifdef SPIKE_SEQ_CTRL_SAT_FLAG_EN
  always_comb begin
    sat_flag = '0;
    for (int unsigned i = 0; i < NCH; i++) sat_flag[i] = &r_cnt[i];
  end
`endif

endmodule

// File: tb/tb_spike_seq_ctrl.sv
// Bench for spike_seq_ctrl: default instance plus a narrow-counter instance sharing stimulus to expose saturation.
module tb_spike_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, cnt_ready;
  logic [7:0]  int_len, frame_len;
  logic [3:0]  settle_len, q_in;
  logic        phase, cnt_valid, busy;
  logic [31:0] cnt_data;
  logic        phase_s, cnt_valid_s, busy_s;
  logic [11:0] cnt_data_s;
`ifdef SPIKE_SEQ_CTRL_SAT_FLAG_EN
  logic [3:0]  sat_flag, sat_flag_s;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  spike_seq_ctrl #(.NCH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .int_len(int_len), .settle_len(settle_len),
    .frame_len(frame_len), .phase(phase), .q_in(q_in), .cnt_data(cnt_data),
    .cnt_valid(cnt_valid), .cnt_ready(cnt_ready),
`ifdef SPIKE_SEQ_CTRL_SAT_FLAG_EN
    .sat_flag(sat_flag),
`endif
    .busy(busy)
  );

  spike_seq_ctrl #(.NCH(4), .CNT_W(3)) dut_s (
    .clk(clk), .rst(rst), .start(start), .int_len(int_len), .settle_len(settle_len),
    .frame_len(frame_len), .phase(phase_s), .q_in(q_in), .cnt_data(cnt_data_s),
    .cnt_valid(cnt_valid_s), .cnt_ready(cnt_ready),
`ifdef SPIKE_SEQ_CTRL_SAT_FLAG_EN
    .sat_flag(sat_flag_s),
`endif
    .busy(busy_s)
  );

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; cnt_ready = 1'b0; q_in = '0;
    int_len = 8'd3; settle_len = 4'd1; frame_len = 8'd2;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({phase, busy, cnt_valid, cnt_data} !== {1'b1, 1'b0, 1'b0, 32'd0})
      $display("FAIL reset_state: got phase=%b busy=%b valid=%b data=%h, want 1 0 0 0",
               phase, busy, cnt_valid, cnt_data);
    else n_pass++;
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, busy_s, cnt_valid_s} !== 3'b000)
      $display("FAIL reset_idle: got busy=%b busy_s=%b valid_s=%b, want 000", busy, busy_s, cnt_valid_s);
    else n_pass++;
  endtask

  // Model: the frame is a list of periods, each max(il,1) integrate cycles then sl+1 compare
  // cycles; q_in on the final compare cycle of each period adds one per high bit, capped at 2^W-1.
  task automatic run_frame(input int il, input int sl, input int fl, input logic [3:0] qv,
                           input bit rnd, input int hold);
    int          il_e, fl_e, per_len;
    int          ecnt [4];
    logic [31:0] ed;
    logic [11:0] eds;
    logic        ephase;
    il_e = (il == 0) ? 1 : il;
    fl_e = (fl == 0) ? 1 : fl;
    per_len = il_e + sl + 1;
    for (int ch = 0; ch < 4; ch++) ecnt[ch] = 0;
    int_len = il[7:0]; settle_len = sl[3:0]; frame_len = fl[7:0];
    start = 1'b1;
    for (int p = 0; p < fl_e; p++) begin
      for (int c = 0; c < per_len; c++) begin
        @(negedge clk);
        ephase = (c >= il_e);
        n_checks++;
        if ({phase, busy, cnt_valid} !== {ephase, 1'b1, 1'b0})
          $display("FAIL frame_phase p=%0d c=%0d: got phase=%b busy=%b valid=%b, want %b 1 0",
                   p, c, phase, busy, cnt_valid, ephase);
        else n_pass++;
        start = 1'($urandom);
        int_len = 8'($urandom); settle_len = 4'($urandom); frame_len = 8'($urandom);
        cnt_ready = 1'($urandom);
        q_in = rnd ? 4'($urandom) : qv;
        if (c == per_len - 1) begin
          for (int ch = 0; ch < 4; ch++) if (q_in[ch]) ecnt[ch]++;
          if (p == fl_e - 1) cnt_ready = 1'b0;
        end
      end
    end
    for (int ch = 0; ch < 4; ch++) begin
      ed[ch*8 +: 8]  = (ecnt[ch] > 255) ? 8'd255 : 8'(ecnt[ch]);
      eds[ch*3 +: 3] = (ecnt[ch] > 7)   ? 3'd7   : 3'(ecnt[ch]);
    end
    for (int h = 0; h <= hold; h++) begin
      @(negedge clk);
      n_checks++;
      if ({phase, busy, cnt_valid, cnt_data} !== {1'b1, 1'b1, 1'b1, ed})
        $display("FAIL out_hold h=%0d: got phase=%b busy=%b valid=%b data=%h, want 1 1 1 %h",
                 h, phase, busy, cnt_valid, cnt_data, ed);
      else n_pass++;
      n_checks++;
      if ({cnt_valid_s, cnt_data_s} !== {1'b1, eds})
        $display("FAIL out_sat_small h=%0d: got valid=%b data=%h, want 1 %h", h, cnt_valid_s, cnt_data_s, eds);
      else n_pass++;
`ifdef SPIKE_SEQ_CTRL_SAT_FLAG_EN
      n_checks++;
      if (sat_flag !== {ed[31:24] == 8'd255, ed[23:16] == 8'd255, ed[15:8] == 8'd255, ed[7:0] == 8'd255})
        $display("FAIL sat_flag: got %b for counts %h", sat_flag, ed);
      else n_pass++;
`endif
      start = (h == hold) ? 1'b0 : 1'($urandom);
      cnt_ready = (h == hold);
    end
    @(negedge clk);
    n_checks++;
    if ({phase, busy, cnt_valid, cnt_data} !== {1'b1, 1'b0, 1'b0, ed})
      $display("FAIL post_transfer: got phase=%b busy=%b valid=%b data=%h, want 1 0 0 %h",
               phase, busy, cnt_valid, cnt_data, ed);
    else n_pass++;
    cnt_ready = 1'b0;
  endtask

  task automatic test_phase_sequence();
    run_frame(3, 1, 2, 4'b0000, 1'b0, 0);
  endtask

  task automatic test_constant_pattern();
    run_frame(int'($urandom_range(1, 5)), int'($urandom_range(0, 3)), 5, 4'b0101, 1'b0, 0);
  endtask

  task automatic test_saturation();
    run_frame(1, 0, 255, 4'b1111, 1'b0, 1);
    run_frame(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 0, 4'b1111, 1'b0, 0);
  endtask

  task automatic test_backpressure();
    run_frame(2, 2, 3, 4'b0000, 1'b1, 20);
  endtask

  task automatic test_midframe_reset();
    int_len = 8'd2; settle_len = 4'd1; frame_len = 8'd4; q_in = 4'b1111;
    start = 1'b1;
    repeat (5) @(negedge clk);
    start = 1'b0;
    n_checks++;
    if ({phase, busy} !== 2'b01)
      $display("FAIL midframe_pre: got phase=%b busy=%b, want 0 1", phase, busy);
    else n_pass++;
    rst = 1'b1; start = 1'b1; cnt_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({phase, busy, cnt_valid, cnt_data} !== {1'b1, 1'b0, 1'b0, 32'd0})
      $display("FAIL midframe_reset: got phase=%b busy=%b valid=%b data=%h, want 1 0 0 0",
               phase, busy, cnt_valid, cnt_data);
    else n_pass++;
    rst = 1'b0; start = 1'b0; cnt_ready = 1'b0;
    @(negedge clk);
    run_frame(1, 1, 3, 4'b0000, 1'b1, 0);
  endtask

  task automatic test_zero_lengths();
    run_frame(0, 0, int'($urandom_range(2, 6)), 4'b0000, 1'b1, 0);
  endtask

  task automatic test_random_frames();
    for (int k = 0; k < 8; k++)
      run_frame(int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), int'($urandom_range(0, 12)),
                4'b0000, 1'b1, int'($urandom_range(0, 3)));
  endtask

  initial begin
    test_reset();
    test_phase_sequence();
    test_constant_pattern();
    test_saturation();
    test_backpressure();
    test_midframe_reset();
    test_zero_lengths();
    test_random_frames();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spike_seq_ctrl.md
SPIKE_SEQ_CTRL -- requirements
Module: spike_seq_ctrl

Interface
REQ-001 Parameter NCH, default 4: number of spikifier channels sequenced in lockstep.
REQ-002 Parameter CNT_W, default 8: width of each per-channel spike counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request a conversion frame; accepted only in IDLE.
REQ-006 int_len  input  8  integrate-phase length in clk cycles; 0 is treated as 1.
REQ-007 settle_len  input  4  compare-phase settle cycles before q sampling.
REQ-008 frame_len  input  8  conversion periods per frame; 0 is treated as 1.
REQ-009 phase  output  1  drives the spikifier clk input: 0 = integrate, 1 = compare/clear.
REQ-010 q_in  input  NCH  spikifier q outputs, one bit per channel.
REQ-011 cnt_data  output  NCH*CNT_W  per-channel spike counts; channel i occupies bits [i*CNT_W +: CNT_W].
REQ-012 cnt_valid  output  1  cnt_data is valid.
REQ-013 cnt_ready  input  1  consumer accepts cnt_data.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, INTEG, COMP and OUT.
REQ-016 IDLE: phase=1 and cnt_valid=0; start=1 at an edge SHALL latch int_len, settle_len and frame_len, clear all counters, and enter INTEG at the next cycle.
REQ-017 INTEG: phase=0 for exactly max(int_len,1) cycles, then COMP.
REQ-018 COMP: phase=1 for exactly settle_len+1 cycles; on the last COMP cycle, each channel with q_in[i]=1 SHALL increment counter i by one.
REQ-019 Each COMP increments a counter at most once per period, regardless of how long q_in stays high.
REQ-020 Counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-021 After the last COMP cycle, the FSM SHALL return to INTEG if fewer than max(frame_len,1) periods have completed, else go to OUT.
REQ-022 OUT: phase=1 and cnt_valid=1, with cnt_data stable; the transfer completes on an edge where cnt_valid and cnt_ready are both 1, and the FSM then returns to IDLE.
REQ-023 While in OUT with cnt_ready=0, the FSM SHALL hold indefinitely with no new integration.
REQ-024 start while busy=1 SHALL be ignored; mid-frame changes to int_len, settle_len or frame_len SHALL have no effect.
REQ-025 In IDLE, cnt_data SHALL retain the last transferred counts until the next accepted start.

Reset
REQ-026 rst=1 at an edge SHALL force IDLE, phase=1, cnt_valid=0, busy=0, all counters and the period and cycle counters to 0, and all latched config to 0.
REQ-027 rst asserted mid-frame SHALL abort the frame immediately; the partial counts are discarded and never presented.
REQ-028 rst takes priority over start and cnt_ready in the same cycle.

Configuration
REQ-029 Macro SPIKE_SEQ_CTRL_SAT_FLAG_EN, when defined, SHALL add output sat_flag [NCH]: bit i is set when counter i reaches saturation, cleared at start or rst, and valid alongside cnt_valid.
REQ-030 Without SPIKE_SEQ_CTRL_SAT_FLAG_EN, the sat_flag port SHALL not exist, and saturation behaviour is otherwise identical.

Verification
REQ-031 Setup: int_len=3, settle_len=1, frame_len=2, start pulse, q_in=0.
- Required: phase sequence after start is 0,0,0,1,1,0,0,0,1,1.
- Required: cnt_valid rises on the next cycle with all counts 0.
REQ-032 Setup: NCH=4, frame_len=5, q_in=4'b0101 held constant, cnt_ready=1.
- Required: counts are ch0=5, ch1=0, ch2=5, ch3=0.
- Required: the FSM is back in IDLE one cycle after the cnt_valid beat.
REQ-033 Setup: CNT_W=8, frame_len=255, then a second frame with frame_len=0, q_in all 1.
- Required: the first frame gives counts of 255 with sat_flag all set when the macro is defined.
- Required: the second frame runs one period and gives a count of 1.
REQ-034 Setup: cnt_ready=0 held 20 cycles in OUT.
- Required: cnt_valid=1, cnt_data and phase=1 stay stable, and start pulses are ignored.
- Required: when cnt_ready=1, the transfer completes in one cycle.
REQ-035 Setup: rst=1 during the second INTEG of a frame_len=4 frame.
- Required: the next cycle shows IDLE, phase=1, busy=0, cnt_valid=0.
- Required: a following start produces counts from zero.
REQ-036 Setup: int_len=0, settle_len=0.
- Required: each period is INTEG 1 cycle followed by COMP 1 cycle.
- Required: q_in is sampled in that single COMP cycle.
